// File: rtl/score_pkg.sv
// Shared types and constants for the two-digit BCD score counter.
package score_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       BCD_MAX   = 4'd9;
    localparam logic [7:0] SCORE_MAX = 8'h99;

    // Out-of-range codes fold back to 0 so a digit can never stay non-BCD.
    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter; chain via carry to build multi-digit BCD counts.
module bcd_digit
    import score_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic hold,
    output bcd_t q,
    output logic carry
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && !hold) begin
            q <= bcd_inc(q);
        end
    end

    assign carry = en && (q == BCD_MAX);

endmodule

// File: rtl/bcd_score_counter.sv
// Snake score counter: rising-edge event counting in BCD plus session high score.
module bcd_score_counter
    import score_pkg::*;
#(
    parameter int SATURATE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output bcd_t ones,
    output bcd_t tens,
    output bcd_t hi_ones,
    output bcd_t hi_tens,
    output logic at_max,
    output logic new_high
);

    logic       inc_q;
    logic       inc_edge;
    logic       sat_hold;
    logic       count;
    logic       ones_carry;
    logic       tens_carry;
    logic [7:0] score_next;

    assign inc_edge = inc && !inc_q;
    assign sat_hold = (SATURATE != 0) && ({tens, ones} == SCORE_MAX);
    assign count    = inc_edge && !clr && !sat_hold;

    bcd_digit u_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (inc_edge),
        .hold  (sat_hold),
        .q     (ones),
        .carry (ones_carry)
    );

    bcd_digit u_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (ones_carry),
        .hold  (sat_hold),
        .q     (tens),
        .carry (tens_carry)
    );

    // Score the digits will hold after this edge, used for the high-score and max decode.
    always_comb begin
        score_next = {tens, ones};
        if (clr) begin
            score_next = 8'h00;
        end else if (count) begin
            score_next[3:0] = bcd_inc(ones);
            if (ones == BCD_MAX) begin
                score_next[7:4] = bcd_inc(tens);
            end
        end
    end

    // inc_q resets high so an inc held through reset release is not counted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inc_q    <= 1'b1;
            hi_ones  <= '0;
            hi_tens  <= '0;
            at_max   <= 1'b0;
            new_high <= 1'b0;
        end else begin
            inc_q    <= inc;
            at_max   <= (score_next == SCORE_MAX);
            new_high <= 1'b0;
            if (count && (score_next > {hi_tens, hi_ones})) begin
                hi_tens  <= score_next[7:4];
                hi_ones  <= score_next[3:0];
                new_high <= 1'b1;
            end
        end
    end

    logic unused_carry;
    assign unused_carry = tens_carry;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Randomized and directed checks of bcd_score_counter (saturating and wrapping builds) against an integer model.
module tb_bcd_score_counter;

    logic clk = 1'b0;
    logic rst;
    logic inc;
    logic clr;

    logic [3:0] ones_s, tens_s, hi_ones_s, hi_tens_s;
    logic       at_max_s, new_high_s;
    logic [3:0] ones_w, tens_w, hi_ones_w, hi_tens_w;
    logic       at_max_w, new_high_w;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Model state; index 0 = saturating build, 1 = wrapping build.
    int sc[2];
    int hs[2];
    bit nh[2];
    bit m_incq;

    logic [17:0] obs_s, obs_w;
    assign obs_s = {tens_s, ones_s, hi_tens_s, hi_ones_s, at_max_s, new_high_s};
    assign obs_w = {tens_w, ones_w, hi_tens_w, hi_ones_w, at_max_w, new_high_w};

    always #5 clk = ~clk;

    bcd_score_counter #(.SATURATE(1)) dut (
        .clk      (clk),
        .reset    (rst),
        .inc      (inc),
        .clr      (clr),
        .ones     (ones_s),
        .tens     (tens_s),
        .hi_ones  (hi_ones_s),
        .hi_tens  (hi_tens_s),
        .at_max   (at_max_s),
        .new_high (new_high_s)
    );

    bcd_score_counter #(.SATURATE(0)) dut_wrap (
        .clk      (clk),
        .reset    (rst),
        .inc      (inc),
        .clr      (clr),
        .ones     (ones_w),
        .tens     (tens_w),
        .hi_ones  (hi_ones_w),
        .hi_tens  (hi_tens_w),
        .at_max   (at_max_w),
        .new_high (new_high_w)
    );

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic logic [17:0] exp_vec(input int s, input int h, input bit n);
        return {to_bcd(s), to_bcd(h), (s == 99), n};
    endfunction

    // Digits must stay BCD on every cycle in both builds.
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if (ones_s > 4'd9 || tens_s > 4'd9 || ones_w > 4'd9 || tens_w > 4'd9) begin
                fails++;
                $display("[TB] FAIL bcd_range: got sat=%h%h wrap=%h%h required digits <= 9",
                         tens_s, ones_s, tens_w, ones_w);
            end
        end
    end

    task automatic drive(input logic r, input logic i, input logic c);
        @(negedge clk);
        rst = r;
        inc = i;
        clr = c;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!r) begin
                sc[m] = 0;
                hs[m] = 0;
                nh[m] = 0;
            end else begin
                nh[m] = 0;
                if (c) begin
                    sc[m] = 0;
                end else if (i && !m_incq) begin
                    if (sc[m] == 99) begin
                        if (m == 1) sc[m] = 0;
                    end else begin
                        sc[m] = sc[m] + 1;
                        if (sc[m] > hs[m]) begin
                            hs[m] = sc[m];
                            nh[m] = 1;
                        end
                    end
                end
            end
        end
        m_incq = r ? i : 1'b1;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0);
        mon_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            tests++;
            if (obs_s !== 18'h0 || obs_w !== 18'h0) begin
                fails++;
                $display("[TB] FAIL reset_held_inc cyc %0d: got sat=%h wrap=%h required 0", k, obs_s, obs_w);
            end
        end
    endtask

    task automatic test_carry();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            tests++;
            if (obs_s !== exp_vec(sc[0], hs[0], nh[0]) || new_high_s !== 1'b1) begin
                fails++;
                $display("[TB] FAIL carry pulse %0d: got %h required %h", k, obs_s, exp_vec(sc[0], hs[0], 1'b1));
            end
            drive(1'b1, 1'b0, 1'b0);
        end
        tests++;
        if ({tens_s, ones_s} !== 8'h10 || {hi_tens_s, hi_ones_s} !== 8'h10) begin
            fails++;
            $display("[TB] FAIL carry_final: got score %h hi %h required 10/10",
                     {tens_s, ones_s}, {hi_tens_s, hi_ones_s});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 105; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            tests++;
            if (obs_s !== exp_vec(sc[0], hs[0], nh[0]) || obs_w !== exp_vec(sc[1], hs[1], nh[1])) begin
                fails++;
                $display("[TB] FAIL sat_step %0d: got sat=%h wrap=%h required sat=%h wrap=%h", k,
                         obs_s, obs_w, exp_vec(sc[0], hs[0], nh[0]), exp_vec(sc[1], hs[1], nh[1]));
            end
            if (k > 99) begin
                tests++;
                if (new_high_s !== 1'b0 || {tens_s, ones_s} !== 8'h99 || at_max_s !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL sat_hold pulse %0d: got score %h at_max %b new_high %b required 99/1/0",
                             k, {tens_s, ones_s}, at_max_s, new_high_s);
                end
            end
            if (k == 100) begin
                tests++;
                if ({tens_w, ones_w} !== 8'h00 || {hi_tens_w, hi_ones_w} !== 8'h99 ||
                    at_max_w !== 1'b0 || new_high_w !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL wrap_100: got score %h hi %h at_max %b new_high %b required 00/99/0/0",
                             {tens_w, ones_w}, {hi_tens_w, hi_ones_w}, at_max_w, new_high_w);
                end
            end
            drive(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_clear_vs_high();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b1);
        tests++;
        if ({tens_s, ones_s} !== 8'h00 || {hi_tens_s, hi_ones_s} !== 8'h07) begin
            fails++;
            $display("[TB] FAIL clear: got score %h hi %h required 00/07", {tens_s, ones_s}, {hi_tens_s, hi_ones_s});
        end
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            tests++;
            if (new_high_s !== (k == 8) || {tens_s, ones_s} !== to_bcd(k)) begin
                fails++;
                $display("[TB] FAIL clear_regrow %0d: got score %h new_high %b required %h/%b",
                         k, {tens_s, ones_s}, new_high_s, to_bcd(k), (k == 8));
            end
            drive(1'b1, 1'b0, 1'b0);
        end
        tests++;
        if ({hi_tens_s, hi_ones_s} !== 8'h08 || new_high_s !== 1'b0) begin
            fails++;
            $display("[TB] FAIL clear_hi: got hi %h new_high %b required 08/0", {hi_tens_s, hi_ones_s}, new_high_s);
        end
    endtask

    task automatic test_collision();
        do_reset();
        for (int k = 0; k < 42; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            tests++;
            if ({tens_s, ones_s} !== 8'h00 || {hi_tens_s, hi_ones_s} !== 8'h42 || new_high_s !== 1'b0) begin
                fails++;
                $display("[TB] FAIL collision_hold %0d: got score %h hi %h required 00/42", k,
                         {tens_s, ones_s}, {hi_tens_s, hi_ones_s});
            end
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        tests++;
        if ({tens_s, ones_s} !== 8'h01 || obs_s !== exp_vec(sc[0], hs[0], nh[0])) begin
            fails++;
            $display("[TB] FAIL collision_rerise: got score %h required 01", {tens_s, ones_s});
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 39) != 0), $urandom_range(0, 1) == 1, ($urandom_range(0, 19) == 0));
            tests++;
            if (obs_s !== exp_vec(sc[0], hs[0], nh[0]) || obs_w !== exp_vec(sc[1], hs[1], nh[1])) begin
                fails++;
                $display("[TB] FAIL random cyc %0d: got sat=%h wrap=%h required sat=%h wrap=%h", k,
                         obs_s, obs_w, exp_vec(sc[0], hs[0], nh[0]), exp_vec(sc[1], hs[1], nh[1]));
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        inc = 1'b0;
        clr = 1'b0;
        m_incq = 1'b1;
        for (int m = 0; m < 2; m++) begin
            sc[m] = 0;
            hs[m] = 0;
            nh[m] = 0;
        end
        test_reset();
        test_carry();
        test_saturation();
        test_clear_vs_high();
        test_collision();
        test_random();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_score_counter.md
# bcd_score_counter

Two-digit BCD score counter for the Snake game. It counts "food eaten" events and tracks the session high score, producing digit-ready BCD nibbles. Its `ones`/`tens` outputs drive the low/high inputs of the existing two-digit 7-segment display wrapper, so it is the producer end of that BCD display interface. It sits between the game FSM and the HEX display logic.

## Interface

**Parameters**
- `SATURATE`, default 1: 1 = hold at 99 on overflow; 0 = wrap 99 → 00.

**Ports**
- `clk`, in, 1: system clock; all state on rising edge.
- `reset`, in, 1: synchronous, active-low (0 = reset), sampled on `clk`.
- `inc`, in, 1: score event level from game FSM; one count per 0→1 transition.
- `clr`, in, 1: synchronous clear of current score (new game); high score kept.
- `ones`, out, 4: current score units digit, BCD 0–9; feeds display `in1` (HEX0).
- `tens`, out, 4: current score tens digit, BCD 0–9; feeds display `in2` (HEX1).
- `hi_ones`, out, 4: high score units digit, BCD.
- `hi_tens`, out, 4: high score tens digit, BCD.
- `at_max`, out, 1: high while score == 99.
- `new_high`, out, 1: one-cycle pulse when the high score is raised.

## Operation

- **Edge detect:** `inc_q` registers `inc`. An increment occurs on an edge where `inc=1 && inc_q=0`. Holding `inc` high yields exactly one count.
- **Increment:**
  - `ones` +1.
  - On `ones==9`: `ones→0` and carry into `tens`.
  - At 99 (`tens==9 && ones==9`):
    - SATURATE=1: no change; no `new_high`.
    - SATURATE=0: wrap to 00; high score unchanged.
- **High score:**
  - Score compared as the 8-bit value `{tens,ones}`; BCD ordering equals numeric ordering.
  - On an increment edge, if the next score > `{hi_tens,hi_ones}`, the high score loads the next score on that same edge and `new_high`=1 for that cycle.
- **Clear:** `clr=1` sets `ones=tens=0`. It does not touch the high score or `new_high` history.
- **Priority:** `reset` > `clr` > increment. When `clr` and an increment edge coincide, the increment is dropped. `inc_q` still updates, so the event is not replayed.
- **Reset values:**
  - All digit outputs 0; `at_max`=0; `new_high`=0.
  - `inc_q`=1, so an `inc` held high through reset release is not counted.
- Digits never hold non-BCD codes (10–15) under any input sequence.

## Timing

- **Latency:** outputs are registered. On an increment edge, the new `ones`/`tens` values, `new_high`, and `at_max` are visible immediately after that edge. The count lands one edge after `inc` first becomes high.
- `at_max` is a registered decode of the updated score, aligned with the digits.
- `new_high` is high for exactly one cycle per raising event.
- **Back-to-back events:** `inc` pulsed 1,0,1,0 on successive cycles gives 2 counts. The minimum event spacing is 2 cycles.
- **Reset mid-operation:** the next edge forces the reset values regardless of `inc`/`clr`.
- Asserting `clr` while `inc` is held high gives no count until `inc` falls and rises again.

## Structure

- Package `score_pkg`:
  - `typedef logic [3:0] bcd_t;`
  - constants `BCD_MAX = 4'd9`, `SCORE_MAX = 8'h99`.
- Sub-module `bcd_digit`:
  - one decade counter with ports `clk`, `reset`, `clr`, `en`, `hold`, `q` (`bcd_t`), `carry`.
  - `carry` = `en && q==9`.
  - instantiated twice (ones, tens) and chained via `carry`.
- Top level contains the edge detector, high-score registers/compare, and the `at_max`/`new_high` logic.

## Test plan

- **Reset and held inc:** hold `reset=0` with `inc=1` for 3 cycles, then release while keeping `inc=1` for 5 cycles → score 00, `hi` 00, no count, `new_high`=0.
- **Carry:** issue 10 separate `inc` pulses from 00 → `ones`=0, `tens`=1 after the 10th. `new_high` pulses each time; `hi`=10.
- **Saturation:** with SATURATE=1, issue 105 pulses → score 99, `at_max`=1, and no `new_high` after reaching 99. Repeat with SATURATE=0: 100 pulses → 00, `hi` stays 99, `at_max`=0.
- **Clear vs. high score:** count to 07, assert `clr` → score 00, `hi` 07. Then count 3 → score 03, `new_high` never pulses. Then count to 08 → `new_high` pulses once, on the edge where the score reaches 08; `hi`=08.
- **Collision:** at score 42, assert `clr` on the same edge as an `inc` rise, with `inc` held high afterward → score 00, no later count until `inc` falls then rises, after which score = 01.
- **Invariant (all scenarios):** assert `ones` ≤ 9 and `tens` ≤ 9 on every cycle. Under random `inc`/`clr`/`reset`, the scoreboard model must match `{tens,ones}` exactly.
